// File: rtl/gamma_ram_seq.sv
// Initiator-side gamma RAM sequencer for the MAP decoder: writes one frame of
// branch metrics (sys+par+apr), then sweeps the dual read port forward and backward.
module gamma_ram_seq #(
  parameter int FRAME_LEN = 128,
  parameter int LLR_W     = 10,
  parameter int GW        = 12,
  parameter int AW        = 13
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [LLR_W-1:0] sys_llr,
  input  logic signed [LLR_W-1:0] par_llr,
  input  logic signed [LLR_W-1:0] apr_llr,
  output logic                    rdwr1,
  output logic [AW-1:0]           index,
  output logic signed [GW-1:0]    in1,
  output logic                    rdwr2,
  output logic [AW-1:0]           index2,
  output logic [AW-1:0]           index3,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  localparam logic [AW-1:0] ZERO_A = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_A  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] FULL_A = AW'(FRAME_LEN);
  localparam logic [AW-1:0] LAST_A = AW'(FRAME_LEN - 1);

  function automatic logic signed [GW-1:0] sext(input logic signed [LLR_W-1:0] v);
    return {{(GW-LLR_W){v[LLR_W-1]}}, v};
  endfunction

  state_e                 state_q, state_d;
  logic [AW-1:0]          wcnt_q, wcnt_d;
  logic                   in_ready_q, in_ready_d;
  logic                   rdwr1_q, rdwr1_d;
  logic [AW-1:0]          index_q, index_d;
  logic signed [GW-1:0]   in1_q, in1_d;
  logic                   rdwr2_q, rdwr2_d;
  logic [AW-1:0]          index2_q, index2_d;
  logic [AW-1:0]          index3_q, index3_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   hs_s;
  logic signed [GW-1:0]   gamma_s;

  // Three sign-extended 10-bit LLRs cannot overflow a 12-bit sum.
  assign gamma_s = sext(sys_llr) + sext(par_llr) + sext(apr_llr);
  assign hs_s    = in_valid & in_ready_q & (state_q == ST_WRITE);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    in_ready_d = 1'b0;
    rdwr1_d    = 1'b1;
    index_d    = index_q;
    in1_d      = in1_q;
    rdwr2_d    = 1'b0;
    index2_d   = ZERO_A;
    index3_d   = ZERO_A;
    rd_valid_d = rdwr2_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wcnt_d = ZERO_A;
        busy_d = start;
        if (start) begin
          state_d    = ST_WRITE;
          in_ready_d = 1'b1;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_WRITE: begin
        busy_d = 1'b1;
        if (hs_s) begin
          rdwr1_d = 1'b0;
          index_d = wcnt_q;
          in1_d   = gamma_s;
          wcnt_d  = wcnt_q + ONE_A;
          if (wcnt_q == LAST_A) begin
            state_d    = ST_GAP;
            in_ready_d = 1'b0;
          end else begin
            in_ready_d = 1'b1;
          end
        end else begin
          in_ready_d = 1'b1;
        end
      end
      ST_GAP: begin
        // The last write lands on this edge; reads start one edge later.
        busy_d   = 1'b1;
        state_d  = ST_READ;
        rdwr2_d  = 1'b1;
        index2_d = ONE_A;
        index3_d = FULL_A;
      end
      ST_READ: begin
        busy_d = 1'b1;
        if (index2_q == FULL_A) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          rdwr2_d  = 1'b1;
          index2_d = index2_q + ONE_A;
          index3_d = index3_q - ONE_A;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= ZERO_A;
      in_ready_q <= 1'b0;
      rdwr1_q    <= 1'b1;
      index_q    <= ZERO_A;
      in1_q      <= {GW{1'b0}};
      rdwr2_q    <= 1'b0;
      index2_q   <= ZERO_A;
      index3_q   <= ZERO_A;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      in_ready_q <= in_ready_d;
      rdwr1_q    <= rdwr1_d;
      index_q    <= index_d;
      in1_q      <= in1_d;
      rdwr2_q    <= rdwr2_d;
      index2_q   <= index2_d;
      index3_q   <= index3_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign rdwr1    = rdwr1_q;
  assign index    = index_q;
  assign in1      = in1_q;
  assign rdwr2    = rdwr2_q;
  assign index2   = index2_q;
  assign index3   = index3_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
